// File: rtl/load_store_unit.sv
// Load/store unit between the pipeline and a word-wide data memory: sub-word lane
// select, extension and read-modify-write stores. Optional macro MISALIGN_TRAP_EN faults misaligned accesses.
module load_store_unit #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_store,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        resp_valid,
  output logic [31:0] load_data,
  output logic        err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] Address,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state_reg, state_next;
  logic [31:0] addr_reg, store_data_reg, rdata_reg;
  logic [1:0]  size_reg;
  logic        is_store_reg, sign_ext_reg, err_reg;

  logic        accept, out_of_range, misalign, fault;
  logic [31:0] store_lanes, merged_word, ext_data;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign accept       = req_valid && req_ready;
  assign out_of_range = {2'b00, addr[31:2]} >= 32'(MEM_WORDS);
`ifdef MISALIGN_TRAP_EN
  assign misalign = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif
  assign fault = out_of_range || misalign;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) begin
        if (fault)                   state_next = RESP;
        else if (is_store && size[1]) state_next = WR;
        else                         state_next = RD;
      end
      RD:   state_next = is_store_reg ? WR : RESP;
      WR:   state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg       <= '0;
      store_data_reg <= '0;
      rdata_reg      <= '0;
      size_reg       <= '0;
      is_store_reg   <= 1'b0;
      sign_ext_reg   <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      if (accept) begin
        addr_reg       <= addr;
        store_data_reg <= store_data;
        size_reg       <= size;
        is_store_reg   <= is_store;
        sign_ext_reg   <= sign_ext;
        err_reg        <= fault;
      end
      if (state_reg == RD) rdata_reg <= ReadData;
    end
  end

  // Replicate the operand across lanes, then pick per byte lane between it and the captured word.
  always_comb begin
    case (size_reg)
      2'b00:   store_lanes = {4{store_data_reg[7:0]}};
      2'b01:   store_lanes = {2{store_data_reg[15:0]}};
      default: store_lanes = store_data_reg;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic lane_hit;
      assign lane_hit = size_reg[1] ||
                        ((size_reg == 2'b01) && (addr_reg[1] == 1'(gi / 2))) ||
                        ((size_reg == 2'b00) && (addr_reg[1:0] == 2'(gi)));
      assign merged_word[8*gi +: 8] = lane_hit ? store_lanes[8*gi +: 8] : rdata_reg[8*gi +: 8];
    end
  endgenerate

  assign sel_byte = rdata_reg[{addr_reg[1:0], 3'b000} +: 8];
  assign sel_half = rdata_reg[{addr_reg[1], 4'b0000} +: 16];

  always_comb begin
    case (size_reg)
      2'b00:   ext_data = {{24{sign_ext_reg & sel_byte[7]}}, sel_byte};
      2'b01:   ext_data = {{16{sign_ext_reg & sel_half[15]}}, sel_half};
      default: ext_data = rdata_reg;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    load_data  = '0;
    err        = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Address    = '0;
    WriteData  = '0;
    case (state_reg)
      IDLE: req_ready = !reset;
      RD: begin
        MemRead = !reset;
        Address = {addr_reg[31:2], 2'b00};
      end
      WR: begin
        MemWrite  = !reset;
        Address   = {addr_reg[31:2], 2'b00};
        WriteData = merged_word;
      end
      RESP: begin
        resp_valid = 1'b1;
        err        = err_reg;
        load_data  = (err_reg || is_store_reg) ? 32'h0 : ext_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural word memory; expected
// responses are queued at issue and checked by an independent monitor.
module tb_load_store_unit;
  localparam int MEM_WORDS = 256;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, is_store = 1'b0, sign_ext = 1'b0;
  logic [1:0]  size = 2'b10;
  logic [31:0] addr = '0, store_data = '0;
  logic        req_ready, resp_valid, err, MemRead, MemWrite;
  logic [31:0] load_data, Address, WriteData, ReadData;

  logic [31:0] mem [MEM_WORDS];
  int          cycle = 0;
  int          n_checks = 0, n_fail = 0;
  bit          bad_strobe = 1'b0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;
  exp_t q[$];

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .is_store(is_store), .size(size), .sign_ext(sign_ext), .addr(addr),
    .store_data(store_data), .resp_valid(resp_valid), .load_data(load_data),
    .err(err), .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address),
    .WriteData(WriteData), .ReadData(ReadData)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  initial for (int i = 0; i < MEM_WORDS; i++) mem[i] = '0;
  assign ReadData = (Address[31:2] < MEM_WORDS) ? mem[Address[9:2]] : 32'h0;
  always @(posedge clk)
    if (MemWrite && Address[31:2] < MEM_WORDS) mem[Address[9:2]] <= WriteData;
  always @(negedge clk)
    if ((MemRead || MemWrite) && Address[31:2] >= MEM_WORDS) bad_strobe = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every response pops one expectation.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("load_data", load_data, e.data);
        check("err", {31'b0, err}, {31'b0, e.err});
        check("latency", 32'(cycle - e.acc + 1), 32'(e.lat));
        $display("resp: load_data=0x%08h err=%0b latency=%0d", load_data, err, cycle - e.acc + 1);
      end
    end
  end

  task automatic issue(input logic st, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] ed, input logic ee, input int lat, input bit push);
    int waitc = 0;
    @(negedge clk);
    while (!req_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (!req_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      return;
    end
    is_store = st; size = sz; sign_ext = sx; addr = a; store_data = d;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (push) q.push_back('{ed, ee, lat, cycle});
    $display("issue: %s size=%0d sx=%0b addr=0x%08h data=0x%08h", st ? "store" : "load", sz, sx, a, d);
  endtask

  task automatic drain();
    int waitc = 0;
    while ((q.size() != 0 || !req_ready) && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    check("drain", 32'(q.size()), 32'd0);
  endtask

  logic [31:0] w4_after;

  initial begin
    @(negedge clk);
    check("reset_ready", {31'b0, req_ready}, 32'd0);
    check("reset_resp", {31'b0, resp_valid}, 32'd0);
    check("reset_ld", load_data, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("ready_after_reset", {31'b0, req_ready}, 32'd1);

    // Word store then load back.
    issue(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, 1);
    issue(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2, 1);
    drain();
    check("mem4_sw", mem[4], 32'hDEADBEEF);

    // Byte store RMW; a request raised while busy must be dropped.
    issue(1, 2'b00, 0, 32'h12, 32'h55, 32'h0, 0, 3, 1);
    is_store = 1; size = 2'b10; addr = 32'h40; store_data = 32'h1; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    drain();
    check("mem4_sb", mem[4], 32'hDE55BEEF);

    issue(0, 2'b00, 1, 32'h13, 0, 32'hFFFFFFDE, 0, 2, 1);
    issue(0, 2'b00, 0, 32'h13, 0, 32'h000000DE, 0, 2, 1);
    issue(0, 2'b01, 1, 32'h12, 0, 32'hFFFFDE55, 0, 2, 1);
    issue(0, 2'b01, 0, 32'h10, 0, 32'h0000BEEF, 0, 2, 1);
    issue(0, 2'b00, 1, 32'h10, 0, 32'hFFFFFFEF, 0, 2, 1);
    issue(0, 2'b11, 1, 32'h10, 0, 32'hDE55BEEF, 0, 2, 1);

    // Range boundaries.
    issue(0, 2'b10, 0, 32'h400, 0, 32'h0, 1, 1, 1);
    issue(1, 2'b10, 0, 32'h3FC, 32'h12345678, 32'h0, 0, 2, 1);
    issue(0, 2'b10, 0, 32'h3FC, 0, 32'h12345678, 0, 2, 1);
    issue(1, 2'b10, 0, 32'h400, 32'hFFFFFFFF, 32'h0, 1, 1, 1);
    drain();

    // Misaligned halfword / word accesses.
    w4_after = TRAP ? 32'hDE55BEEF : 32'hDE55A5A5;
    issue(1, 2'b01, 0, 32'h11, 32'hA5A5, 32'h0, TRAP, TRAP ? 1 : 3, 1);
    drain();
    check("mem4_sh_mis", mem[4], w4_after);
    issue(1, 2'b10, 0, 32'h23, 32'hCAFEF00D, 32'h0, TRAP, TRAP ? 1 : 2, 1);
    issue(0, 2'b10, 0, 32'h20, 0, TRAP ? 32'h0 : 32'hCAFEF00D, 0, 2, 1);
    issue(0, 2'b10, 0, 32'h12, 0, TRAP ? 32'h0 : w4_after, TRAP, TRAP ? 1 : 2, 1);
    drain();

    // Reset during the WR cycle of a byte store.
    issue(1, 2'b00, 0, 32'h12, 32'h77, 32'h0, 0, 3, 0);
    for (int i = 0; i < 10 && !MemWrite; i++) @(negedge clk);
    check("wr_reached", {31'b0, MemWrite}, 32'd1);
    reset = 1'b1;
    #1;
    check("wr_gated", {31'b0, MemWrite}, 32'd0);
    check("ready_in_reset", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("ready_post_reset", {31'b0, req_ready}, 32'd1);
    check("mem4_reset", mem[4], w4_after);
    repeat (4) @(negedge clk);

    check("ignored_req_mem", mem[16], 32'h0);
    check("oor_strobe", {31'b0, bad_strobe}, 32'd0);
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end
endmodule
